// File: rtl/operand_fwd_ctrl.sv
// Hazard/forwarding controller for the 32x16 operand register bank.
// Latency: RA/RB/id_ready are combinational; selects and RW_dm are registered (1 cycle).
// Backpressure: id_ready=0 for one cycle on a load-use hazard; upstream holds id_* inputs.
//
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   id_valid/ra/rb/rw/wr/load/imm   decoded instruction from the decode stage
//   id_ready               instruction accepted this cycle (0 = stall)
//   RA, RB                 bank read addresses (pass-through of id_ra/id_rb)
//   RW_dm                  bank write address, aligned with the M slot
//   mux_sel_A/B            operand source: 00 bank, 01 ans_ex, 10 ans_dm, 11 ans_wb
//   imm_sel                operand B takes the immediate
//   ex_valid               E slot holds a real instruction
//   stall_cnt              saturating count of stall cycles
//
// Optional feature macro: ZERO_REG_EN -- register NOP_REG is hardwired zero; it is
// never forwarded, never causes a stall, and writes to it are not tracked.
module operand_fwd_ctrl #(
    parameter logic [4:0] NOP_REG = 5'd0,
    parameter int         CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_ra,
    input  logic [4:0]       id_rb,
    input  logic [4:0]       id_rw,
    input  logic             id_wr,
    input  logic             id_load,
    input  logic             id_imm,
    output logic             id_ready,
    output logic [4:0]       RA,
    output logic [4:0]       RB,
    output logic [4:0]       RW_dm,
    output logic [1:0]       mux_sel_A,
    output logic [1:0]       mux_sel_B,
    output logic             imm_sel,
    output logic             ex_valid,
    output logic [CNT_W-1:0] stall_cnt
);

    // In-flight destination tags. Only E needs to remember loads: by the time a
    // load reaches M its result is on ans_dm and can be forwarded.
    logic       e_valid, e_wr, e_load;
    logic [4:0] e_rw;
    logic       m_valid, m_wr;
    logic [4:0] m_rw;
    logic       w_valid, w_wr;
    logic [4:0] w_rw;

    logic       use_a, use_b, hazard, accept, id_wr_tag;
    logic [1:0] sel_a_nxt, sel_b_nxt;

    // A slot supplies a source operand when it holds a valid writer of that register.
    function automatic logic src_hit(input logic [4:0] src, input logic v,
                                     input logic wr, input logic [4:0] rw);
`ifdef ZERO_REG_EN
        return v & wr & (rw == src) & (src != NOP_REG);
`else
        return v & wr & (rw == src);
`endif
    endfunction

    // Nearest producer wins, so a younger writer shadows older ones. Bubbles
    // still occupy their slot, keeping the select aligned with the result bus.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic ev, input logic ew, input logic [4:0] er,
                                           input logic mv, input logic mw, input logic [4:0] mr,
                                           input logic wv, input logic ww, input logic [4:0] wr_);
        if (src_hit(src, ev, ew, er))       return 2'b01;
        else if (src_hit(src, mv, mw, mr))  return 2'b10;
        else if (src_hit(src, wv, ww, wr_)) return 2'b11;
        else                                return 2'b00;
    endfunction

    assign RA       = id_ra;
    assign RB       = id_rb;
    assign ex_valid = e_valid;

    always_comb begin
        use_a  = id_valid;
        use_b  = id_valid & ~id_imm;
        // Only a load in E stalls: its data is not ready until it reaches M.
        hazard = e_valid & e_wr & e_load &
                 ((use_a & src_hit(id_ra, e_valid, e_wr, e_rw)) |
                  (use_b & src_hit(id_rb, e_valid, e_wr, e_rw)));
        id_ready = ~hazard;
        accept   = id_valid & ~hazard;
`ifdef ZERO_REG_EN
        id_wr_tag = id_wr & (id_rw != NOP_REG);
`else
        id_wr_tag = id_wr;
`endif
        // B select tracks id_rb even for immediates; imm_sel overrides it downstream.
        sel_a_nxt = fwd_sel(id_ra, e_valid, e_wr, e_rw, m_valid, m_wr, m_rw, w_valid, w_wr, w_rw);
        sel_b_nxt = fwd_sel(id_rb, e_valid, e_wr, e_rw, m_valid, m_wr, m_rw, w_valid, w_wr, w_rw);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_valid   <= 1'b0;
            e_wr      <= 1'b0;
            e_load    <= 1'b0;
            e_rw      <= NOP_REG;
            m_valid   <= 1'b0;
            m_wr      <= 1'b0;
            m_rw      <= NOP_REG;
            w_valid   <= 1'b0;
            w_wr      <= 1'b0;
            w_rw      <= NOP_REG;
            mux_sel_A <= 2'b00;
            mux_sel_B <= 2'b00;
            imm_sel   <= 1'b0;
            RW_dm     <= NOP_REG;
            stall_cnt <= '0;
        end else begin
            // No downstream stall: the pipe always advances, bubble or not.
            m_valid <= e_valid;
            m_wr    <= e_wr;
            m_rw    <= e_rw;
            w_valid <= m_valid;
            w_wr    <= m_wr;
            w_rw    <= m_rw;
            // The E tag becomes next cycle's M tag, which is what RW_dm must show.
            RW_dm   <= (e_valid & e_wr) ? e_rw : NOP_REG;

            if (accept) begin
                e_valid   <= 1'b1;
                e_wr      <= id_wr_tag;
                e_load    <= id_load;
                e_rw      <= id_rw;
                mux_sel_A <= sel_a_nxt;
                mux_sel_B <= sel_b_nxt;
                imm_sel   <= id_imm;
            end else begin
                e_valid   <= 1'b0;
                e_wr      <= 1'b0;
                e_load    <= 1'b0;
                e_rw      <= NOP_REG;
                mux_sel_A <= 2'b00;
                mux_sel_B <= 2'b00;
                imm_sel   <= 1'b0;
            end

            if (id_valid & hazard & ~(&stall_cnt))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_operand_fwd_ctrl.sv
module tb_operand_fwd_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_wr, id_load, id_imm;
    logic [4:0] id_ra, id_rb, id_rw;
    logic       id_ready, imm_sel, ex_valid;
    logic [4:0] RA, RB, RW_dm;
    logic [1:0] mux_sel_A, mux_sel_B;
    logic [2:0] stall_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0] a;
        logic [1:0] b;
        logic       imm;
        logic       exv;
        logic [4:0] rw;
        logic [2:0] cnt;
    } exp_t;

    exp_t sb[$];

    // Small counter width so saturation is reachable in a short run.
    operand_fwd_ctrl #(.NOP_REG(5'd0), .CNT_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .id_valid  (id_valid),
        .id_ra     (id_ra),
        .id_rb     (id_rb),
        .id_rw     (id_rw),
        .id_wr     (id_wr),
        .id_load   (id_load),
        .id_imm    (id_imm),
        .id_ready  (id_ready),
        .RA        (RA),
        .RB        (RB),
        .RW_dm     (RW_dm),
        .mux_sel_A (mux_sel_A),
        .mux_sel_B (mux_sel_B),
        .imm_sel   (imm_sel),
        .ex_valid  (ex_valid),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] ra, input logic [4:0] rb,
                         input logic [4:0] rw, input logic wr, input logic ld, input logic im);
        id_valid = v;
        id_ra    = ra;
        id_rb    = rb;
        id_rw    = rw;
        id_wr    = wr;
        id_load  = ld;
        id_imm   = im;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".rdy"}, 16'(id_ready),  16'd1);
        chk({tag, ".exv"}, 16'(ex_valid),  16'd0);
        chk({tag, ".sa"},  16'(mux_sel_A), 16'd0);
        chk({tag, ".sb"},  16'(mux_sel_B), 16'd0);
        chk({tag, ".imm"}, 16'(imm_sel),   16'd0);
        chk({tag, ".rw"},  16'(RW_dm),     16'd0);
        chk({tag, ".cnt"}, 16'(stall_cnt), 16'd0);
    endtask

    // One pipeline cycle: drive the instruction, check the combinational
    // outputs, queue the expected registered outputs, then compare after the edge.
    task automatic cyc(input string tag,
                       input logic v, input logic [4:0] ra, input logic [4:0] rb,
                       input logic [4:0] rw, input logic wr, input logic ld, input logic im,
                       input logic erdy, input logic [1:0] ea, input logic [1:0] eb,
                       input logic eimm, input logic eexv, input logic [4:0] erw,
                       input logic [2:0] ecnt);
        exp_t e;
        drive(v, ra, rb, rw, wr, ld, im);
        #2;
        chk({tag, ".rdy"}, 16'(id_ready), 16'(erdy));
        chk({tag, ".RA"},  16'(RA),       16'(ra));
        chk({tag, ".RB"},  16'(RB),       16'(rb));
        e = '{a: ea, b: eb, imm: eimm, exv: eexv, rw: erw, cnt: ecnt};
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 16'(sb.size()), 16'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, ".sa"},  16'(mux_sel_A), 16'(e.a));
            chk({tag, ".sb"},  16'(mux_sel_B), 16'(e.b));
            chk({tag, ".imm"}, 16'(imm_sel),   16'(e.imm));
            chk({tag, ".exv"}, 16'(ex_valid),  16'(e.exv));
            chk({tag, ".rw"},  16'(RW_dm),     16'(e.rw));
            chk({tag, ".cnt"}, 16'(stall_cnt), 16'(e.cnt));
        end
    endtask

    initial begin
        logic [1:0] zsel;
        logic [2:0] cprev, cnow;
`ifdef ZERO_REG_EN
        zsel = 2'b00;
`else
        zsel = 2'b01;
`endif
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk_reset("reset");
        #12 rst_n = 1'b1;
        @(posedge clk);
        #1;

        //   tag   v  ra  rb  rw wr ld im   rdy sa     sb     imm exv rw  cnt
        // Independent ALU ops: no forwarding, RW_dm follows one edge behind E.
        cyc("alu1", 1, 10, 11, 1, 1, 0, 0, 1, 2'b00, 2'b00, 0, 1, 0, 0);
        cyc("alu2", 1, 12, 13, 2, 1, 0, 0, 1, 2'b00, 2'b00, 0, 1, 1, 0);
        cyc("alu3", 1, 14, 15, 3, 1, 0, 0, 1, 2'b00, 2'b00, 0, 1, 2, 0);
        cyc("idl1", 0,  0,  0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 3, 0);
        cyc("idl2", 0,  0,  0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0);

        // Forwarding chain from r5 at distances 1, 2, 3.
        cyc("w5",   1, 20, 21, 5, 1, 0, 0, 1, 2'b00, 2'b00, 0, 1, 0, 0);
        cyc("ch_e", 1,  5,  5, 9, 0, 0, 0, 1, 2'b01, 2'b01, 0, 1, 5, 0);
        cyc("ch_m", 1,  5,  5, 9, 0, 0, 0, 1, 2'b10, 2'b10, 0, 1, 0, 0);
        cyc("ch_w", 1,  5,  5, 9, 0, 0, 0, 1, 2'b11, 2'b11, 0, 1, 0, 0);

        // Two writers of r6: the younger (E) wins.
        cyc("w6a",  1, 20, 21, 6, 1, 0, 0, 1, 2'b00, 2'b00, 0, 1, 0, 0);
        cyc("w6b",  1, 20, 21, 6, 1, 0, 0, 1, 2'b00, 2'b00, 0, 1, 6, 0);
        cyc("tie",  1,  6,  6, 9, 0, 0, 0, 1, 2'b01, 2'b01, 0, 1, 6, 0);

        // Load-use: one bubble, then forward from ans_dm.
        cyc("ld7",  1, 20, 21, 7, 1, 1, 0, 1, 2'b00, 2'b00, 0, 1, 0, 0);
        cyc("stl",  1,  7, 22, 9, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 7, 1);
        cyc("pst",  1,  7, 22, 9, 0, 0, 0, 1, 2'b10, 2'b00, 0, 1, 0, 1);

        // Load followed by an immediate op whose rb matches: no stall.
        cyc("ld7i", 1, 20, 21, 7, 1, 1, 0, 1, 2'b00, 2'b00, 0, 1, 0, 1);
        cyc("imm",  1,  3,  7, 9, 0, 0, 1, 1, 2'b00, 2'b01, 1, 1, 7, 1);

        // Writer to register 0, then a reader of register 0.
        cyc("w0",   1, 20, 21, 0, 1, 0, 0, 1, 2'b00, 2'b00, 0, 1, 0, 1);
        cyc("rd0",  1,  0, 22, 9, 0, 0, 0, 1, zsel,  2'b00, 0, 1, 0, 1);
        cyc("idl3", 0,  0,  0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0, 1);

        // Repeated load-use stalls drive the 3-bit counter into saturation.
        for (int i = 0; i < 7; i++) begin
            cprev = (i + 1 > 7) ? 3'd7 : 3'(i + 1);
            cnow  = (i + 2 > 7) ? 3'd7 : 3'(i + 2);
            cyc("sat_ld",  1, 20, 21, 7, 1, 1, 0, 1, 2'b00, 2'b00, 0, 1, 0, cprev);
            cyc("sat_stl", 1,  7, 22, 9, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 7, cnow);
            cyc("sat_pst", 1,  7, 22, 9, 0, 0, 0, 1, 2'b10, 2'b00, 0, 1, 0, cnow);
        end

        // Reset asserted in the middle of a stall cycle.
        cyc("rld7", 1, 20, 21, 7, 1, 1, 0, 1, 2'b00, 2'b00, 0, 1, 0, 7);
        drive(1, 7, 22, 9, 0, 0, 0);
        #2;
        chk("rst_pre.rdy", 16'(id_ready), 16'd0);
        rst_n = 1'b0;
        #1;
        chk_reset("rst_mid");
        #1 rst_n = 1'b1;
        cyc("rst_iss", 1, 7, 22, 9, 0, 0, 0, 1, 2'b00, 2'b00, 0, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
